// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path: default geometry and
// a reference one-hot helper for the default register count.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DEPTH  = 32;
    localparam int REG_ZERO   = 0;

    function automatic logic [REG_DEPTH-1:0] onehot(input logic [REG_ADDR_W-1:0] addr);
        return {{(REG_DEPTH-1){1'b0}}, 1'b1} << addr;
    endfunction

endpackage

// File: rtl/regfile_we_decoder_if.sv
// Request/response bundle between the issue logic and the write-enable decoder.
interface regfile_we_decoder_if
    import regfile_pkg::*;
#(
    parameter int ADDR_W    = REG_ADDR_W,
    parameter int DEPTH     = REG_DEPTH,
    parameter int NUM_PORTS = 2
);
    logic                          en;
    logic [NUM_PORTS-1:0]          wr_valid;
    logic [NUM_PORTS*ADDR_W-1:0]   wr_addr;
    logic                          rsv_valid;
    logic [ADDR_W-1:0]             rsv_addr;
    logic [NUM_PORTS*DEPTH-1:0]    we_out;
    logic [DEPTH-1:0]              we_all;
    logic                          conflict;
    logic                          range_err;
    logic [DEPTH-1:0]              busy;

    modport master (
        output en, wr_valid, wr_addr, rsv_valid, rsv_addr,
        input  we_out, we_all, conflict, range_err, busy
    );

    modport slave (
        input  en, wr_valid, wr_addr, rsv_valid, rsv_addr,
        output we_out, we_all, conflict, range_err, busy
    );
endinterface

// File: rtl/regfile_we_decoder_onehot_dec.sv
// Combinational single-port decode: address plus qualifying request to a
// DEPTH-bit one-hot vector (all zeros when req is low).
module we_onehot_dec #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              req,
    output logic [DEPTH-1:0]  oh
);
    always_comb begin
        oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            oh[i] = req && (addr == ADDR_W'(i));
        end
    end
endmodule

// File: rtl/regfile_we_decoder.sv
// Registered multi-port write-enable decoder with youngest-wins collision
// masking, range flagging, optional register-0 lock and a busy scoreboard.
module regfile_we_decoder
    import regfile_pkg::*;
#(
    parameter int ADDR_W    = REG_ADDR_W,
    parameter int DEPTH     = REG_DEPTH,
    parameter int NUM_PORTS = 2,
    parameter int ZERO_LOCK = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_we_decoder_if.slave bus
);
    logic [ADDR_W-1:0]          addr [NUM_PORTS];
    logic [DEPTH-1:0]           raw [NUM_PORTS];
    logic [DEPTH-1:0]           masked [NUM_PORTS];
    logic [NUM_PORTS-1:0]       req;
    logic [NUM_PORTS-1:0]       bad;
    logic [NUM_PORTS*DEPTH-1:0] we_c;
    logic [DEPTH-1:0]           we_all_c;
    logic [DEPTH-1:0]           set_c;
    logic                       conflict_c;
    logic                       range_err_c;
    logic                       rsv_req;

    logic [NUM_PORTS*DEPTH-1:0] we_p1;
    logic [DEPTH-1:0]           we_all_p1;
    logic [DEPTH-1:0]           busy_p1;
    logic                       conflict_p1;
    logic                       range_err_p1;

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W+1)'(DEPTH);
    endfunction

    function automatic logic is_locked(input logic [ADDR_W-1:0] a);
        return (ZERO_LOCK != 0) && (a == ADDR_W'(REG_ZERO));
    endfunction

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign addr[p] = bus.wr_addr[p*ADDR_W +: ADDR_W];
        assign req[p]  = bus.en && bus.wr_valid[p] && in_range(addr[p]) && !is_locked(addr[p]);
        assign bad[p]  = bus.en && bus.wr_valid[p] && !in_range(addr[p]);

        we_onehot_dec #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dec (
            .addr (addr[p]),
            .req  (req[p]),
            .oh   (raw[p])
        );
    end

    // An older port loses its enable to any younger port hitting the same register.
    always_comb begin
        conflict_c = 1'b0;
        we_all_c   = '0;
        we_c       = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            masked[p] = raw[p];
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int q = p + 1; q < NUM_PORTS; q++) begin
                if (req[p] && req[q] && (addr[p] == addr[q])) begin
                    masked[p]  = '0;
                    conflict_c = 1'b1;
                end
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            we_c[p*DEPTH +: DEPTH] = masked[p];
            we_all_c               = we_all_c | masked[p];
        end
    end

    assign range_err_c = |bad;
    assign rsv_req     = bus.rsv_valid && in_range(bus.rsv_addr) && !is_locked(bus.rsv_addr);

    we_onehot_dec #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rsv_dec (
        .addr (bus.rsv_addr),
        .req  (rsv_req),
        .oh   (set_c)
    );

    // ---- stage p1: registered enables, flags and scoreboard ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_p1        <= '0;
            we_all_p1    <= '0;
            conflict_p1  <= 1'b0;
            range_err_p1 <= 1'b0;
            busy_p1      <= '0;
        end else begin
            we_p1        <= we_c;
            we_all_p1    <= we_all_c;
            conflict_p1  <= conflict_c;
            range_err_p1 <= range_err_c;
            busy_p1      <= (busy_p1 & ~we_all_p1) | set_c;
        end
    end

    assign bus.we_out    = we_p1;
    assign bus.we_all    = we_all_p1;
    assign bus.conflict  = conflict_p1;
    assign bus.range_err = range_err_p1;
    assign bus.busy      = busy_p1;
endmodule
